// File: rtl/fp_add_system_if.sv
// Board-facing signal bundle for fp_add_system.
//   en         : step button (asynchronous to the system clock)
//   leds       : upper byte of the latest sum
//   an0, a0-g0 : digit 0 enable and segments (active-low), low nibble of leds
//   an1, a1-g1 : digit 1 enable and segments (active-low), high nibble of leds
// slave is the design side, master is the board/stimulus side.
interface fp_add_system_if;
  logic       en;
  logic [7:0] leds;
  logic       an0, a0, b0, c0, d0, e0, f0, g0;
  logic       an1, a1, b1, c1, d1, e1, f1, g1;

  modport slave (
    input  en,
    output leds,
    output an0, a0, b0, c0, d0, e0, f0, g0,
    output an1, a1, b1, c1, d1, e1, f1, g1
  );

  modport master (
    output en,
    input  leds,
    input  an0, a0, b0, c0, d0, e0, f0, g0,
    input  an1, a1, b1, c1, d1, e1, f1, g1
  );
endinterface

// File: rtl/fp_add_system.sv
// Memory-driven single-precision FP adder demo top level.
// Each rising edge of the synchronised en button adds the next operand pair from a fixed
// table with a multi-cycle IEEE-754 binary32 adder (round-to-nearest-even, denormals
// treated as zero, underflow flushed to +0) and shows result[31:24] on the LEDs and two
// hexadecimal 7-segment digits.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   io  : board signals (en in; leds, an0/an1 and segment outputs)
module fp_add_system #(
  parameter int unsigned NUM = 10
) (
  input logic             clk,
  input logic             rst,
  fp_add_system_if.slave  io
);

  localparam int unsigned PtrW = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StUnpack, StAlign, StAdd, StNorm, StRound
  } state_e;

  // Operand table: {A, B}.
  function automatic logic [63:0] table_entry(input logic [PtrW-1:0] idx);
    logic [63:0] v;
    case (int'(idx))
      0:       v = {32'h3F800000, 32'h3F800000};
      1:       v = {32'h3F800000, 32'h40000000};
      2:       v = {32'h40A00000, 32'hC0A00000};
      3:       v = {32'h7F7FFFFF, 32'h7F7FFFFF};
      4:       v = {32'h3F800000, 32'h33800000};
      5:       v = {32'h7F800000, 32'hFF800000};
      6:       v = {32'h3FC00000, 32'h3FC00000};
      7:       v = {32'hC1200000, 32'h40A00000};
      8:       v = {32'h00400000, 32'h3F800000};
      9:       v = {32'h42280000, 32'h3F000000};
      default: v = '0;
    endcase
    return v;
  endfunction

  // Active-low glyphs, bit order a..g.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_e state_q, state_d;

  logic            sync1_q, sync2_q, prev_q;
  logic            rise;
  logic [PtrW-1:0] ptr_q;

  logic [31:0] op_a_q, op_b_q;
  logic        sa_q, sb_q;
  logic [7:0]  ea_q, eb_q;
  logic [23:0] ma_q, mb_q;
  logic        special_q;
  logic [31:0] special_res_q;
  logic        sign_q, sub_q;
  logic [7:0]  exp_q;
  logic [26:0] mbig_q, msmall_q;
  logic [27:0] sum_q;
  logic [26:0] norm_m_q;
  logic signed [10:0] norm_e_q;
  logic        zero_q;
  logic [31:0] result_q;
  logic        done_q;

  // Two-flop synchroniser plus previous-value flop for edge detection.
  assign rise = sync2_q & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= StIdle;
    end else begin
      sync1_q <= io.en;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (rise) state_d = StFetch;
      StFetch:  state_d = StUnpack;
      StUnpack: state_d = StAlign;
      StAlign:  state_d = StAdd;
      StAdd:    state_d = StNorm;
      StNorm:   state_d = StRound;
      StRound:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Unpack: denormals become signed zero; infinities and NaNs resolve here.
  logic        unp_sa, unp_sb;
  logic [7:0]  unp_ea, unp_eb;
  logic [23:0] unp_ma, unp_mb;
  logic        unp_special;
  logic [31:0] unp_special_res;
  logic        a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    unp_sa = op_a_q[31];
    unp_sb = op_b_q[31];
    unp_ea = op_a_q[30:23];
    unp_eb = op_b_q[30:23];
    unp_ma = (unp_ea == 8'd0) ? 24'd0 : {1'b1, op_a_q[22:0]};
    unp_mb = (unp_eb == 8'd0) ? 24'd0 : {1'b1, op_b_q[22:0]};
    a_nan  = (unp_ea == 8'hFF) && (op_a_q[22:0] != 23'd0);
    b_nan  = (unp_eb == 8'hFF) && (op_b_q[22:0] != 23'd0);
    a_inf  = (unp_ea == 8'hFF) && (op_a_q[22:0] == 23'd0);
    b_inf  = (unp_eb == 8'hFF) && (op_b_q[22:0] == 23'd0);
    unp_special = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (unp_sa != unp_sb))) begin
      unp_special_res = 32'h7FC00000;
    end else if (a_inf) begin
      unp_special_res = {unp_sa, 8'hFF, 23'd0};
    end else begin
      unp_special_res = {unp_sb, 8'hFF, 23'd0};
    end
  end

  // Align: larger magnitude becomes the big operand; the other is shifted right with
  // guard/round/sticky kept in the three low bits.
  logic        a_ge_b;
  logic [7:0]  big_e, small_e, diff;
  logic [23:0] big_m, small_m;
  logic [26:0] ext_small, shifted, mask, aligned_small;
  logic        sticky;

  always_comb begin
    a_ge_b  = {ea_q, ma_q} >= {eb_q, mb_q};
    big_e   = a_ge_b ? ea_q : eb_q;
    small_e = a_ge_b ? eb_q : ea_q;
    big_m   = a_ge_b ? ma_q : mb_q;
    small_m = a_ge_b ? mb_q : ma_q;
    diff    = big_e - small_e;
    ext_small = {small_m, 3'b000};
    mask    = '0;
    if (diff >= 8'd27) begin
      shifted = '0;
      sticky  = |small_m;
    end else begin
      shifted = ext_small >> diff;
      mask    = (27'd1 << diff) - 27'd1;
      sticky  = |(ext_small & mask);
    end
    aligned_small = {shifted[26:1], shifted[0] | sticky};
  end

  // Normalise: bring the leading one to bit 26.
  logic [4:0]         lz;
  logic [26:0]        nrm_m;
  logic signed [10:0] nrm_e;

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum_q[i]) lz = 5'(26 - i);
    end
    if (sum_q[27]) begin
      nrm_m = {sum_q[27:2], sum_q[1] | sum_q[0]};
      nrm_e = $signed({3'b000, exp_q}) + 11'sd1;
    end else begin
      nrm_m = sum_q[26:0] << lz;
      nrm_e = $signed({3'b000, exp_q}) - $signed({6'b000000, lz});
    end
  end

  // Round to nearest even, then range checks.
  logic               round_up;
  logic [24:0]        rnd_m25;
  logic [23:0]        rnd_m;
  logic signed [10:0] rnd_e;
  logic [31:0]        rnd_res;

  always_comb begin
    round_up = norm_m_q[2] & (norm_m_q[1] | norm_m_q[0] | norm_m_q[3]);
    rnd_m25  = {1'b0, norm_m_q[26:3]} + {24'd0, round_up};
    rnd_e    = norm_e_q;
    rnd_m    = rnd_m25[23:0];
    if (rnd_m25[24]) begin
      rnd_m = rnd_m25[24:1];
      rnd_e = norm_e_q + 11'sd1;
    end
    if (special_q) begin
      rnd_res = special_res_q;
    end else if (zero_q) begin
      rnd_res = 32'd0;
    end else if (rnd_e >= 11'sd255) begin
      rnd_res = {sign_q, 8'hFF, 23'd0};
    end else if (rnd_e <= 11'sd0) begin
      rnd_res = 32'd0;
    end else begin
      rnd_res = {sign_q, rnd_e[7:0], rnd_m[22:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q         <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      sa_q          <= 1'b0;
      sb_q          <= 1'b0;
      ea_q          <= '0;
      eb_q          <= '0;
      ma_q          <= '0;
      mb_q          <= '0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      sign_q        <= 1'b0;
      sub_q         <= 1'b0;
      exp_q         <= '0;
      mbig_q        <= '0;
      msmall_q      <= '0;
      sum_q         <= '0;
      norm_m_q      <= '0;
      norm_e_q      <= '0;
      zero_q        <= 1'b0;
      result_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          {op_a_q, op_b_q} <= table_entry(ptr_q);
          ptr_q <= (ptr_q == PtrW'(NUM - 1)) ? '0 : ptr_q + 1'b1;
        end
        StUnpack: begin
          sa_q          <= unp_sa;
          sb_q          <= unp_sb;
          ea_q          <= unp_ea;
          eb_q          <= unp_eb;
          ma_q          <= unp_ma;
          mb_q          <= unp_mb;
          special_q     <= unp_special;
          special_res_q <= unp_special_res;
        end
        StAlign: begin
          sign_q   <= a_ge_b ? sa_q : sb_q;
          sub_q    <= sa_q ^ sb_q;
          exp_q    <= big_e;
          mbig_q   <= {big_m, 3'b000};
          msmall_q <= aligned_small;
        end
        StAdd: begin
          // Big magnitude is never below small, so the difference cannot go negative.
          sum_q <= sub_q ? ({1'b0, mbig_q} - {1'b0, msmall_q})
                         : ({1'b0, mbig_q} + {1'b0, msmall_q});
        end
        StNorm: begin
          zero_q   <= (sum_q == 28'd0);
          norm_m_q <= nrm_m;
          norm_e_q <= nrm_e;
        end
        StRound: begin
          result_q <= rnd_res;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Digits stay blank until the first result has been written.
  logic [6:0] seg0, seg1;
  always_comb begin
    seg0 = done_q ? hex7(result_q[27:24]) : 7'b1111111;
    seg1 = done_q ? hex7(result_q[31:28]) : 7'b1111111;
  end

  assign io.leds = result_q[31:24];
  assign io.an0  = ~done_q;
  assign io.an1  = ~done_q;
  assign {io.a0, io.b0, io.c0, io.d0, io.e0, io.f0, io.g0} = seg0;
  assign {io.a1, io.b1, io.c1, io.d1, io.e1, io.f1, io.g1} = seg1;

endmodule

// File: tb/tb_fp_add_system.sv
module tb_fp_add_system;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fp_add_system_if bus ();

  fp_add_system #(.NUM(10)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] Glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Expected upper result bytes for entries 3..9.
  localparam logic [7:0] SeqByte [7] = '{8'h7F, 8'h3F, 8'h7F, 8'h40, 8'hC0, 8'h3F, 8'h42};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_blank(input string tag);
    check_eq({tag, "/leds"}, 32'(bus.leds), 32'h00);
    check_eq({tag, "/an"}, 32'({bus.an1, bus.an0}), 32'b11);
    check_eq({tag, "/seg1"}, 32'({bus.a1, bus.b1, bus.c1, bus.d1, bus.e1, bus.f1, bus.g1}),
             32'h7F);
    check_eq({tag, "/seg0"}, 32'({bus.a0, bus.b0, bus.c0, bus.d0, bus.e0, bus.f0, bus.g0}),
             32'h7F);
  endtask

  task automatic check_display(input string tag, input logic [7:0] val);
    check_eq({tag, "/leds"}, 32'(bus.leds), 32'(val));
    check_eq({tag, "/an"}, 32'({bus.an1, bus.an0}), 32'b00);
    check_eq({tag, "/seg1"}, 32'({bus.a1, bus.b1, bus.c1, bus.d1, bus.e1, bus.f1, bus.g1}),
             32'(Glyph[val[7:4]]));
    check_eq({tag, "/seg0"}, 32'({bus.a0, bus.b0, bus.c0, bus.d0, bus.e0, bus.f0, bus.g0}),
             32'(Glyph[val[3:0]]));
  endtask

  task automatic press(input int high, input int low);
    bus.en = 1'b1;
    cycles(high);
    bus.en = 1'b0;
    cycles(low);
  endtask

  initial begin
    bus.en = 1'b0;
    rst    = 1'b1;
    cycles(1);
    check_blank("in_reset");
    rst = 1'b0;
    cycles(3);
    check_blank("after_reset");

    // Entry 0, held high: output not yet written mid-flight, then one addition only.
    bus.en = 1'b1;
    cycles(5);
    check_blank("e0_early");
    cycles(125);
    bus.en = 1'b0;
    check_display("e0", 8'h40);
    cycles(10);

    press(12, 10);
    check_display("e1", 8'h40);

    press(20, 90);
    check_display("e2", 8'h00);

    for (int i = 0; i < 7; i++) begin
      press(12, 10);
      check_display($sformatf("e%0d", i + 3), SeqByte[i]);
    end

    // Wrap back to entry 0.
    press(12, 10);
    check_display("wrap_e0", 8'h40);

    // Second rising edge lands while busy and must be dropped.
    bus.en = 1'b1;
    cycles(3);
    bus.en = 1'b0;
    cycles(2);
    bus.en = 1'b1;
    cycles(3);
    bus.en = 1'b0;
    cycles(12);
    check_display("busy_e1", 8'h40);
    press(12, 10);
    check_display("busy_e2", 8'h00);

    // Reset during entry 3 aborts it and rewinds the pointer.
    bus.en = 1'b1;
    cycles(5);
    rst    = 1'b1;
    bus.en = 1'b0;
    cycles(1);
    rst = 1'b0;
    check_blank("mid_rst");
    cycles(15);
    check_blank("mid_rst_hold");
    press(12, 10);
    check_display("rst_e0", 8'h40);
    cycles(40);
    check_display("hold_e0", 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
